// File: rtl/multi_operand_accumulator.sv
// Two-stage pipelined sum of N_OPS masked unsigned operands, optionally folded
// into a saturating running accumulator; valid/ready handshakes on both sides.
module multi_operand_accumulator #(
  parameter int N_OPS = 4,
  parameter int IN_W  = 4,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_OPS*IN_W-1:0]   operands,
  input  logic [N_OPS-1:0]        op_mask,
  input  logic                    acc_mode,
  input  logic                    acc_clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        sum,
  output logic                    overflow
);

  generate
    if (N_OPS < 2 || N_OPS > 16) begin : g_bad_n_ops
      $error("multi_operand_accumulator: N_OPS must lie in 2..16");
    end
    if (OUT_W < IN_W + $clog2(N_OPS)) begin : g_bad_out_w
      $error("multi_operand_accumulator: OUT_W cannot hold the full operand sum");
    end
  endgenerate

  // Exact zero-extended sum of the operands whose mask bit is set.
  function automatic logic [OUT_W-1:0] masked_sum(
    input logic [N_OPS*IN_W-1:0] ops,
    input logic [N_OPS-1:0]      mask
  );
    logic [OUT_W-1:0] total_v;
    total_v = '0;
    for (int k = 0; k < N_OPS; k++) begin
      total_v = total_v + (mask[k] ? OUT_W'(ops[k*IN_W +: IN_W]) : '0);
    end
    return total_v;
  endfunction

  logic             s1_valid_r;
  logic [OUT_W-1:0] s1_sum_r;
  logic             s1_mode_r;
  logic             s1_clear_r;

  logic             out_valid_r;
  logic [OUT_W-1:0] sum_r;
  logic             overflow_r;
  logic [OUT_W-1:0] acc_r;

  logic             stage1_adv_s;
  logic             stage2_adv_s;
  logic [OUT_W-1:0] base_s;
  logic [OUT_W:0]   total_s;
  logic [OUT_W-1:0] result_s;
  logic [OUT_W-1:0] acc_next_s;
  logic             ovf_s;

  // Each stage moves only when the slot ahead of it is free or draining.
  assign stage2_adv_s = !out_valid_r || out_ready;
  assign stage1_adv_s = !s1_valid_r || stage2_adv_s;
  assign in_ready     = stage1_adv_s && !reset;

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign overflow  = overflow_r;

  // Stage 1: capture the masked operand sum together with mode and clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= '0;
      s1_mode_r  <= 1'b0;
      s1_clear_r <= 1'b0;
    end else if (stage1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sum_r   <= masked_sum(operands, op_mask);
        s1_mode_r  <= acc_mode;
        s1_clear_r <= acc_clear;
      end
    end
  end

  // Stage 2 result: plain pass-through or saturating accumulate; one spare
  // carry bit detects saturation.
  always_comb begin
    base_s     = '0;
    total_s    = '0;
    result_s   = s1_sum_r;
    ovf_s      = 1'b0;
    acc_next_s = acc_r;
    base_s     = s1_clear_r ? '0 : acc_r;
    total_s    = {1'b0, base_s} + {1'b0, s1_sum_r};
    if (s1_mode_r) begin
      if (total_s[OUT_W]) begin
        result_s   = '1;
        ovf_s      = 1'b1;
        acc_next_s = '1;
      end else begin
        result_s   = total_s[OUT_W-1:0];
        ovf_s      = 1'b0;
        acc_next_s = total_s[OUT_W-1:0];
      end
    end else begin
      result_s   = s1_sum_r;
      ovf_s      = 1'b0;
      acc_next_s = s1_clear_r ? '0 : acc_r;
    end
  end

  // Stage 2 registers: results and accumulator change only when a beat loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      overflow_r  <= 1'b0;
      acc_r       <= '0;
    end else if (stage2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        sum_r      <= result_s;
        overflow_r <= ovf_s;
        acc_r      <= acc_next_s;
      end
    end
  end

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Scoreboard bench for multi_operand_accumulator (defaults N_OPS=4, IN_W=4, OUT_W=8).
module tb_multi_operand_accumulator;

  typedef struct packed {
    logic [7:0] s;
    logic       o;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] operands;
  logic [3:0]  op_mask;
  logic        acc_mode;
  logic        acc_clear;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sum;
  logic        overflow;

  exp_t sb[$];
  exp_t obs_q[$];
  int   acc_m;
  logic accepted;
  int   checks = 0;
  int   failures = 0;

  multi_operand_accumulator #(.N_OPS(4), .IN_W(4), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operands(operands), .op_mask(op_mask), .acc_mode(acc_mode),
    .acc_clear(acc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // One clock: model accepted beats, record delivered results, flush on reset.
  task automatic tick();
    exp_t e;
    int   s;
    int   t;
    @(negedge clk);
    accepted = in_valid && in_ready;
    if (accepted) begin
      s = 0;
      for (int k = 0; k < 4; k++) if (op_mask[k]) s += int'(operands[k*4 +: 4]);
      if (!acc_mode) begin
        e = '{s: 8'(s), o: 1'b0};
        if (acc_clear) acc_m = 0;
      end else begin
        t = (acc_clear ? 0 : acc_m) + s;
        if (t > 255) begin acc_m = 255; e = '{s: 8'd255, o: 1'b1}; end
        else begin acc_m = t; e = '{s: 8'(t), o: 1'b0}; end
      end
      sb.push_back(e);
    end
    if (out_valid === 1'b1 && out_ready) obs_q.push_back('{s: sum, o: overflow});
    if (reset) begin sb.delete(); obs_q.delete(); acc_m = 0; end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [3:0] m, input logic mode,
                          input logic clr);
    operands  = {d, c, b, a};
    op_mask   = m;
    acc_mode  = mode;
    acc_clear = clr;
  endtask

  task automatic send();
    int b = 0;
    in_valid = 1'b1;
    do begin tick(); b++; end while (!accepted && b < 50);
    checks++;
    if (!accepted) begin failures++; $display("FAIL send_timeout: accepted=%0b want=1", accepted); end
  endtask

  task automatic drain();
    int b = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (obs_q.size() < sb.size() && b < 300) begin tick(); b++; end
    checks++;
    if (obs_q.size() < sb.size()) begin
      failures++;
      $display("FAIL drain_timeout: results=%0d required=%0d", obs_q.size(), sb.size());
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_beat(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'd0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b sum=%0d overflow=%b in_ready=%b want 0/0/0/0",
               out_valid, sum, overflow, in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_plain();
    exp_t es = '{s: 8'd17, o: 1'b0};
    set_beat(4'd3, 4'd5, 4'd2, 4'd7, 4'b1111, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (accepted !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL plain_latency1: accepted=%b out_valid=%b want 1/0", accepted, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'd17 || overflow !== 1'b0) begin
      failures++; $display("FAIL plain_latency2: out_valid=%b sum=%0d ovf=%b want 1/17/0", out_valid, sum, overflow);
    end
    drain();
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL plain_count: got=%0d want=1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== sb[0] || obs_q[0] !== es) begin
        failures++; $display("FAIL plain_sum: sum=%0d ovf=%b want 17/0", obs_q[0].s, obs_q[0].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  task automatic test_mask();
    exp_t es[2] = '{'{s: 8'd30, o: 1'b0}, '{s: 8'd0, o: 1'b0}};
    set_beat(4'd15, 4'd15, 4'd15, 4'd15, 4'b0101, 1'b0, 1'b0); send();
    set_beat(4'd15, 4'd15, 4'd15, 4'd15, 4'b0000, 1'b0, 1'b0); send();
    drain();
    checks++;
    if (obs_q.size() != 2) begin failures++; $display("FAIL mask_count: got=%0d want=2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      checks++;
      if (obs_q[i] !== sb[i] || obs_q[i] !== es[i]) begin
        failures++; $display("FAIL mask_sum[%0d]: sum=%0d ovf=%b want %0d/%b", i, obs_q[i].s, obs_q[i].o, es[i].s, es[i].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  task automatic test_accumulate();
    exp_t es[6] = '{'{8'd60, 1'b0}, '{8'd120, 1'b0}, '{8'd180, 1'b0},
                    '{8'd240, 1'b0}, '{8'd255, 1'b1}, '{8'd10, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      set_beat(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 1'b1, (i == 0) ? 1'b1 : 1'b0);
      send();
    end
    set_beat(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 1'b1); send();
    drain();
    checks++;
    if (obs_q.size() != 6) begin failures++; $display("FAIL acc_count: got=%0d want=6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 6; i++) begin
      checks++;
      if (obs_q[i] !== sb[i] || obs_q[i] !== es[i]) begin
        failures++; $display("FAIL acc_sum[%0d]: sum=%0d ovf=%b want %0d/%b", i, obs_q[i].s, obs_q[i].o, es[i].s, es[i].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  task automatic test_back_pressure();
    exp_t       es[4] = '{'{8'd10, 1'b0}, '{8'd20, 1'b0}, '{8'd30, 1'b0}, '{8'd40, 1'b0}};
    int         n_acc = 0;
    int         b = 0;
    logic [7:0] held = 8'd0;
    logic       held_v = 1'b0;
    out_ready = 1'b0;
    set_beat(4'd1, 4'd2, 4'd3, 4'd4, 4'b1111, 1'b1, 1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (accepted) begin n_acc++; acc_clear = 1'b0; end
      if (out_valid === 1'b1) begin
        if (!held_v) begin held = sum; held_v = 1'b1; end
        else begin
          checks++;
          if (sum !== held) begin failures++; $display("FAIL bp_hold: sum=%0d want %0d", sum, held); end
        end
      end
    end
    checks++;
    if (n_acc != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 8'd10) begin
      failures++;
      $display("FAIL bp_stall: accepted=%0d in_ready=%b out_valid=%b sum=%0d want 2/0/1/10",
               n_acc, in_ready, out_valid, sum);
    end
    out_ready = 1'b1;
    while (n_acc < 4 && b < 50) begin
      tick(); b++;
      if (accepted) n_acc++;
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (obs_q.size() != 4) begin failures++; $display("FAIL bp_count: got=%0d want=4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      checks++;
      if (obs_q[i] !== sb[i] || obs_q[i] !== es[i]) begin
        failures++; $display("FAIL bp_sum[%0d]: sum=%0d ovf=%b want %0d/%b", i, obs_q[i].s, obs_q[i].o, es[i].s, es[i].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midstream();
    exp_t es = '{s: 8'd4, o: 1'b0};
    out_ready = 1'b1;
    set_beat(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 1'b1, 1'b1); send();
    set_beat(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 1'b1, 1'b0); send();
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[1] !== '{s: 8'd120, o: 1'b0}) begin
      failures++; $display("FAIL mid_preload: results=%0d want 2 ending in 120", obs_q.size());
    end
    sb.delete(); obs_q.delete();
    out_ready = 1'b0;
    send(); send();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || sum !== 8'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state: out_valid=%b sum=%0d ovf=%b want 0/0/0", out_valid, sum, overflow);
    end
    out_ready = 1'b1;
    set_beat(4'd1, 4'd1, 4'd1, 4'd1, 4'b1111, 1'b1, 1'b0); send();
    drain();
    checks++;
    if (obs_q.size() != 1) begin failures++; $display("FAIL mid_count: got=%0d want=1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] !== sb[0] || obs_q[0] !== es) begin
        failures++; $display("FAIL mid_sum: sum=%0d ovf=%b want 4/0", obs_q[0].s, obs_q[0].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    int n = 0;
    int cyc = 0;
    while (n < 1000 && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      operands  = 16'($urandom);
      op_mask   = 4'($urandom);
      acc_mode  = ($urandom_range(0, 3) != 0);
      acc_clear = ($urandom_range(0, 15) == 0);
      tick(); cyc++;
      if (accepted) n++;
    end
    checks++;
    if (n != 1000) begin failures++; $display("FAIL rand_accept: got=%0d want=1000", n); end
    drain();
    checks++;
    if (obs_q.size() != sb.size()) begin
      failures++; $display("FAIL rand_count: got=%0d want=%0d", obs_q.size(), sb.size());
    end
    for (int i = 0; i < obs_q.size() && i < sb.size(); i++) begin
      checks++;
      if (obs_q[i] !== sb[i]) begin
        failures++; $display("FAIL rand_sum[%0d]: sum=%0d ovf=%b want %0d/%b", i, obs_q[i].s, obs_q[i].o, sb[i].s, sb[i].o);
      end
    end
    sb.delete(); obs_q.delete();
  endtask

  initial begin
    acc_m = 0;
    accepted = 1'b0;
    test_reset();
    test_plain();
    test_mask();
    test_accumulate();
    test_back_pressure();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
